decode_sequencer: RTL and testbench

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer.sv | 101 ++++++++++
 tb/tb_decode_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Iteration sequencer for a layered LDPC decoder: holds the channel LLRs and the
// message vector, feeds one layer evaluation per cycle and hands back the final messages.
`ifndef INT_SIZE
`define INT_SIZE 32
`endif

module decode_sequencer #(
  parameter int WIDTH  = 8,
  parameter int N_V    = 44,
  parameter int E      = 147,
  parameter int ITER_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ITER_W-1:0]      n_iter,
  input  logic [WIDTH*N_V-1:0]   llr_in,
  output logic [WIDTH*N_V-1:0]   layer_llrs,
  output logic [WIDTH*E-1:0]     layer_prev,
  output logic [`INT_SIZE-1:0]   bias_idx,
  input  logic [WIDTH*E-1:0]     layer_proc,
  output logic [WIDTH*E-1:0]     result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [ITER_W-1:0]      iter_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [ITER_W-1:0] ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [WIDTH*N_V-1:0]   llr_q, llr_d;
  logic [WIDTH*E-1:0]     msg_q, msg_d;
  logic [ITER_W-1:0]      n_q, n_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic [ITER_W-1:0]      last_iter;

  // n_q is never 0 while in RUN, so this never underflows
  assign last_iter = n_q - ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      llr_q   <= '0;
      msg_q   <= '0;
      n_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      llr_q   <= llr_d;
      msg_q   <= msg_d;
      n_q     <= n_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    llr_d   = llr_q;
    msg_d   = msg_q;
    n_d     = n_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          llr_d   = llr_in;
          n_d     = (n_iter == '0) ? ONE : n_iter;
          msg_d   = '0;
          iter_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          msg_d = layer_proc;
          // Counter stops at the last index instead of wrapping past 2^ITER_W-1
          if (iter_q == last_iter) state_d = HOLD;
          else                     iter_d  = iter_q + ONE;
        end
      end
      HOLD: begin
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign layer_llrs = llr_q;
  assign layer_prev = msg_q;
  assign result     = msg_q;
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign iter_cnt   = iter_q;
  assign bias_idx   = {{(`INT_SIZE-ITER_W){1'b0}}, iter_q};

endmodule

// File: tb/tb_decode_sequencer.sv
// Randomized scoreboard bench for decode_sequencer with a simple additive layer model.
`ifndef INT_SIZE
`define INT_SIZE 32
`endif

module tb_decode_sequencer;
  localparam int W  = 8;
  localparam int NV = 5;
  localparam int NE = 7;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rst, start, abort, out_ready;
  logic [IW-1:0]        n_iter;
  logic [W*NV-1:0]      llr_in, layer_llrs;
  logic [W*NE-1:0]      layer_prev, layer_proc, result;
  logic [`INT_SIZE-1:0] bias_idx;
  logic                 out_valid, busy;
  logic [IW-1:0]        iter_cnt;

  decode_sequencer #(.WIDTH(W), .N_V(NV), .E(NE), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_iter(n_iter),
    .llr_in(llr_in), .layer_llrs(layer_llrs), .layer_prev(layer_prev),
    .bias_idx(bias_idx), .layer_proc(layer_proc), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          start_cyc;
    int          n_eff;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] inc[NE];
  bit         bias_on;

  always @(posedge clk) cyc <= cyc + 1;

  // Layer stand-in: each element adds a per-element increment, its variable's LLR and optionally the bias index
  always_comb begin
    layer_proc = '0;
    for (int e = 0; e < NE; e++)
      layer_proc[e*W +: W] = layer_prev[e*W +: W] + inc[e] + layer_llrs[(e%NV)*W +: W]
                             + (bias_on ? bias_idx[W-1:0] : 8'd0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // After n passes each element is n*(inc+llr) plus the sum of indices 0..n-1, all mod 256
  function automatic logic [63:0] model(input int n, input logic [W*NV-1:0] llr);
    int          ne;
    int          v;
    logic [63:0] r;
    ne = (n == 0) ? 1 : n;
    r  = '0;
    for (int e = 0; e < NE; e++) begin
      v = ne * (int'(inc[e]) + int'(llr[(e%NV)*W +: W])) + (bias_on ? ne * (ne - 1) / 2 : 0);
      r[e*W +: W] = 8'(v);
    end
    return r;
  endfunction

  task automatic issue(input int n, input bit rnd_llr, input bit push);
    logic [63:0] r64;
    exp_t        x;
    r64    = {$urandom(), $urandom()};
    start  = 1'b1;
    n_iter = IW'(n);
    llr_in = rnd_llr ? r64[W*NV-1:0] : '0;
    if (push) begin
      x.res       = model(n, llr_in);
      x.start_cyc = cyc + 1;
      x.n_eff     = (n == 0) ? 1 : n;
      sb.push_back(x);
    end
    $display("issue n_iter=%0d llr=%0h push=%0d", n, llr_in, push);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_hold(input int n, input bit chk);
    int k;
    int ne;
    k  = 0;
    ne = (n == 0) ? 1 : n;
    while (!out_valid && k < 40) begin
      if (chk) begin
        check("bias_idx", 64'(bias_idx), 64'(k));
        check("iter_cnt", 64'(iter_cnt), 64'(k));
      end
      k++;
      @(negedge clk);
    end
    check("reach_hold", 64'(out_valid), 64'd1);
    if (chk) check("iter_hold", 64'(iter_cnt), 64'(ne - 1));
  endtask

  task automatic release_hold(input int hold, input bit with_start);
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("held_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    start     = with_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_ready", 64'(busy), 64'd0);
    check("valid_cleared", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("start_ignored", 64'(busy), 64'd0);
  endtask

  task automatic decode(input int n, input bit rnd_llr, input bit chk, input int hold, input bit with_start);
    issue(n, rnd_llr, 1'b1);
    run_to_hold(n, chk);
    release_hold(hold, with_start);
  endtask

  // Monitor: pops on each rising out_valid, then checks result stays put while held
  initial begin
    logic [63:0] held;
    bit          pv;
    exp_t        x;
    pv   = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          x = sb.pop_front();
          check("result", 64'(result), x.res);
          check("latency", 64'(cyc - x.start_cyc), 64'(x.n_eff));
          $display("output result=%0h exp=%0h latency=%0d", result, x.res, cyc - x.start_cyc);
        end
        held = 64'(result);
      end else if (out_valid) begin
        check("result_stable", 64'(result), held);
      end
      pv = out_valid;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    n_iter = '0; llr_in = '0; bias_on = 1'b0;
    for (int e = 0; e < NE; e++) inc[e] = 8'd1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_iter", 64'(iter_cnt), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // prev+1 layer, n_iter=3: all elements end at 3, bias 0,1,2
    decode(3, 1'b0, 1'b1, 0, 1'b0);
    // n_iter=0 behaves as 1
    decode(0, 1'b0, 1'b1, 0, 1'b0);
    // five stalled cycles then handshake with a coincident start
    decode(5, 1'b1, 1'b1, 5, 1'b1);

    // abort at iteration 2 of 6
    issue(6, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_at_iter", 64'(iter_cnt), 64'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    repeat (8) @(negedge clk);
    decode(2, 1'b1, 1'b1, 0, 1'b0);

    // abort in HOLD beats out_ready
    issue(2, 1'b1, 1'b1);
    run_to_hold(2, 1'b1);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("hold_abort_idle", 64'(busy), 64'd0);
    check("hold_abort_valid", 64'(out_valid), 64'd0);

    // start and abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1; n_iter = 4'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'(busy), 64'd0);
    @(negedge clk);

    // asynchronous reset between edges during RUN
    issue(8, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_iter", 64'(iter_cnt), 64'd0);
    check("arst_bias", 64'(bias_idx), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_prev", 64'(layer_prev), 64'd0);
    check("arst_llrs", 64'(layer_llrs), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    decode(4, 1'b1, 1'b1, 1, 1'b0);

    // maximum iteration count, no wrap
    decode(15, 1'b0, 1'b1, 0, 1'b0);

    // randomized decodes with bias folded into the layer
    bias_on = 1'b1;
    for (int t = 0; t < 20; t++) begin
      for (int e = 0; e < NE; e++) inc[e] = 8'($urandom_range(0, 255));
      decode(int'($urandom_range(0, 15)), 1'b1, 1'b1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
